motor_ramp: RTL and testbench

- Upstream command stage for the dual-motor PWM driver. Accepts target speed/direction commands and slews each motor's PWM duty toward its target in fixed steps.
- Direction reversals always pass through zero duty first.
- Emits full 24-bit motor words on the driver's write channel, in the driver's format. Each emitted write also makes the driver return and clear its distance counters.

---
 rtl/motor_ramp.sv | 157 +++++++++++++++
 tb/tb_motor_ramp.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_ramp.sv
// motor_ramp: command stage ahead of the dual-motor PWM driver.
// Latches target speed/direction words and slews each motor's duty toward its
// target by STEP every TICK_DIV clocks. A reversal always ramps through zero.
// Every tick that changes either motor emits one full word on the write channel.
// Optional feature: define RAMP_ESTOP_EN to add the estop input, which forces
// both duties to zero and emits an immediate write tagged 4'hE.
module motor_ramp #(
  parameter int PWM_W    = 11,
  parameter int TICK_DIV = 50000,
  parameter int STEP     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               cmd_ctrl,
  input  logic [2*(PWM_W+1)-1:0]   cmd_data,
  input  logic                     cmd_wr,
  output logic [3:0]               out_ctrl,
  output logic [2*(PWM_W+1)-1:0]   out_data,
  output logic                     out_wr,
`ifdef RAMP_ESTOP_EN
  input  logic                     estop,
`endif
  output logic                     busy
);

  // One motor field is {dir, pwm}; the packed word holds motor 2 above motor 1.
  localparam int MW    = PWM_W + 1;
  localparam int WW    = 2 * MW;
  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] tick_cnt;
  logic [WW-1:0]    cur_word;
  logic [WW-1:0]    tgt_word;
  logic [3:0]       tag;
  logic             tick;

  logic [WW-1:0]    nxt_word;
  logic [WW-1:0]    cur_after;
  logic [WW-1:0]    tgt_after;
  logic [WW-1:0]    data_after;
  logic [3:0]       ctrl_after;
  logic [3:0]       tag_after;
  logic             wr_after;
  logic [CNT_W-1:0] cnt_after;

  // One ramp step for a single motor field. The arithmetic is one bit wider
  // than the duty so differences and sums never wrap.
  function automatic logic [MW-1:0] step_motor(input logic [MW-1:0] cur,
                                               input logic [MW-1:0] tgt);
    logic             cd;
    logic             td;
    logic [PWM_W:0]   c;
    logic [PWM_W:0]   t;
    logic [PWM_W:0]   s;
    logic [PWM_W:0]   d;
    logic             nd;
    logic [PWM_W:0]   np;
    cd = cur[PWM_W];
    td = tgt[PWM_W];
    c  = {1'b0, cur[PWM_W-1:0]};
    t  = {1'b0, tgt[PWM_W-1:0]};
    s  = (PWM_W+1)'(STEP);
    d  = '0;
    nd = cd;
    np = c;
    if (cd != td) begin
      // Wrong direction: bleed duty to zero first, then flip the direction.
      if (c != '0) np = (c > s) ? (c - s) : '0;
      else         nd = td;
    end else if (c < t) begin
      d  = t - c;
      np = (d > s) ? (c + s) : t;
    end else if (c > t) begin
      d  = c - t;
      np = (d > s) ? (c - s) : t;
    end
    return {nd, np[PWM_W-1:0]};
  endfunction

`ifdef RAMP_ESTOP_EN
  logic estop_q;

  // Zero both duty fields of a packed word while keeping the direction bits.
  function automatic logic [WW-1:0] clear_pwm(input logic [WW-1:0] w);
    logic [WW-1:0] r;
    r = '0;
    r[PWM_W]      = w[PWM_W];
    r[MW + PWM_W] = w[MW + PWM_W];
    return r;
  endfunction
`endif

  assign tick = (tick_cnt == TICK_LAST);

  // Candidate next duty/direction for both motors, from pre-edge state.
  always_comb begin
    nxt_word = cur_word;
    for (int m = 0; m < 2; m++) begin
      nxt_word[m*MW +: MW] = step_motor(cur_word[m*MW +: MW], tgt_word[m*MW +: MW]);
    end
  end

  // Post-edge values of every register; estop overrides the normal path.
  always_comb begin
    cnt_after  = tick ? '0 : tick_cnt + 1'b1;
    cur_after  = tick ? nxt_word : cur_word;
    tgt_after  = cmd_wr ? cmd_data : tgt_word;
    tag_after  = cmd_wr ? cmd_ctrl : tag;
    wr_after   = tick && (nxt_word != cur_word);
    data_after = wr_after ? nxt_word : out_data;
    ctrl_after = wr_after ? tag_after : out_ctrl;
`ifdef RAMP_ESTOP_EN
    if (estop) begin
      cnt_after  = '0;
      cur_after  = clear_pwm(cur_word);
      tgt_after  = clear_pwm(tgt_word);
      tag_after  = tag;
      wr_after   = !estop_q;
      data_after = estop_q ? out_data : clear_pwm(cur_word);
      ctrl_after = estop_q ? out_ctrl : 4'hE;
    end
`endif
  end

  // State, output and busy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      cur_word <= '0;
      tgt_word <= '0;
      tag      <= '0;
      out_wr   <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
      busy     <= 1'b0;
    end else begin
      tick_cnt <= cnt_after;
      cur_word <= cur_after;
      tgt_word <= tgt_after;
      tag      <= tag_after;
      out_wr   <= wr_after;
      out_data <= data_after;
      out_ctrl <= ctrl_after;
      busy     <= (cur_after != tgt_after);
    end
  end

`ifdef RAMP_ESTOP_EN
  // Remember the previous estop level so only its first cycle forces a write.
  always_ff @(posedge clk) begin
    if (rst) estop_q <= 1'b0;
    else     estop_q <= estop;
  end
`endif

endmodule

// File: tb/tb_motor_ramp.sv
// Testbench for motor_ramp: directed ramp scenarios followed by random
// commands, checked by a scoreboard fed from a behavioural model.
module tb_motor_ramp;

  localparam int TICK_DIV = 4;
  localparam int STEP     = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cmd_ctrl = '0;
  logic [23:0] cmd_data = '0;
  logic        cmd_wr = 1'b0;
  logic [3:0]  out_ctrl;
  logic [23:0] out_data;
  logic        out_wr;
  logic        busy;
  logic        estop = 1'b0;

  motor_ramp #(.PWM_W(11), .TICK_DIV(TICK_DIV), .STEP(STEP)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_ctrl(cmd_ctrl),
    .cmd_data(cmd_data),
    .cmd_wr(cmd_wr),
    .out_ctrl(out_ctrl),
    .out_data(out_data),
    .out_wr(out_wr),
`ifdef RAMP_ESTOP_EN
    .estop(estop),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [23:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_writes = 0;
  bit   started = 0;

  // Reference state kept as plain integers: per-motor dir/duty, target, tag.
  int   m_cnt = 0;
  int   cd[2], cp[2], td[2], tp[2];
  int   m_tag = 0;
  bit   m_busy = 0;
  bit   m_estop_q = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [23:0] mk(input int d2, input int p2, input int d1, input int p1);
    return {1'(d2), 11'(p2), 1'(d1), 11'(p1)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s actual=timeout required=condition at %0t", name, $time);
  endtask

  // Behavioural model: on every clock edge apply the ramp rules, queue writes.
  always @(posedge clk) begin
    bit tick;
    bit changed;
    int pd;
    int pc;
    if (rst) begin
      m_cnt = 0; m_tag = 0; m_busy = 0; m_estop_q = 0;
      for (int m = 0; m < 2; m++) begin cd[m] = 0; cp[m] = 0; td[m] = 0; tp[m] = 0; end
      exp_q.delete();
    end else begin
      if (estop) begin
        if (!m_estop_q) exp_q.push_back('{4'hE, mk(cd[1], 0, cd[0], 0)});
        for (int m = 0; m < 2; m++) begin cp[m] = 0; tp[m] = 0; end
        m_cnt = 0;
      end else begin
        tick = (m_cnt == TICK_DIV - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        if (tick) begin
          changed = 0;
          for (int m = 0; m < 2; m++) begin
            pd = cd[m];
            pc = cp[m];
            if (cd[m] != td[m]) begin
              if (cp[m] != 0) cp[m] = cp[m] - imin(STEP, cp[m]);
              else            cd[m] = td[m];
            end else if (cp[m] < tp[m]) begin
              cp[m] = cp[m] + imin(STEP, tp[m] - cp[m]);
            end else if (cp[m] > tp[m]) begin
              cp[m] = cp[m] - imin(STEP, cp[m] - tp[m]);
            end
            if (pd != cd[m] || pc != cp[m]) changed = 1;
          end
          if (changed)
            exp_q.push_back('{cmd_wr ? cmd_ctrl : 4'(m_tag), mk(cd[1], cp[1], cd[0], cp[0])});
        end
        if (cmd_wr) begin
          m_tag = int'(cmd_ctrl);
          td[0] = int'(cmd_data[11]);
          tp[0] = int'(cmd_data[10:0]);
          td[1] = int'(cmd_data[23]);
          tp[1] = int'(cmd_data[22:12]);
        end
      end
      m_estop_q = estop;
      m_busy = (cd[0] != td[0]) || (cp[0] != tp[0]) || (cd[1] != td[1]) || (cp[1] != tp[1]);
    end
  end

  // Monitor: away from the active edge, pop and compare each DUT write.
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      checkOutput("busy", 32'(busy), 32'(m_busy));
      if (out_wr === 1'b1) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_wr", 32'(out_wr), 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("wr_ctrl", 32'(out_ctrl), 32'(e.ctrl));
          checkOutput("wr_data", 32'(out_data), 32'(e.data));
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] ctrl, input logic [23:0] data);
    cmd_ctrl = ctrl;
    cmd_data = data;
    cmd_wr   = 1'b1;
    @(negedge clk);
    cmd_wr   = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait until the model has no open gap, then flush the last write.
  task automatic settle(input string name, input int max);
    int n;
    n = 0;
    while (m_busy && n < max) begin @(negedge clk); n++; end
    if (n >= max) timeoutFail(name);
    waitCycles(TICK_DIV + 2);
    checkOutput(name, 32'(busy), 32'd0);
  endtask

  task automatic waitPwm1(input string name, input int thr, input int max);
    int n;
    n = 0;
    while (cp[0] < thr && n < max) begin @(negedge clk); n++; end
    if (n >= max) timeoutFail(name);
  endtask

  initial begin
    int w0;
    int n;
    for (int m = 0; m < 2; m++) begin cd[m] = 0; cp[m] = 0; td[m] = 0; tp[m] = 0; end
    @(negedge clk);
    doReset();
    started = 1;
    checkOutput("rst_out_wr", 32'(out_wr), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_ctrl", 32'(out_ctrl), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);

    // Ramp up 0 -> 250: three writes, 100/200/250.
    $display("[TB] ramp up");
    w0 = n_writes;
    applyStimulus(4'd3, mk(0, 0, 0, 250));
    checkOutput("t1_busy_rise", 32'(busy), 32'd1);
    settle("t1_settle", 100);
    checkOutput("t1_writes", 32'(n_writes - w0), 32'd3);

    // Reversal 150 fwd -> 120 rev: 50, 0, 0(flip), 100, 120.
    $display("[TB] reversal");
    applyStimulus(4'd4, mk(0, 0, 0, 150));
    settle("t2a_settle", 100);
    w0 = n_writes;
    applyStimulus(4'd4, mk(0, 0, 1, 120));
    settle("t2_settle", 100);
    checkOutput("t2_writes", 32'(n_writes - w0), 32'd5);
    checkOutput("t2_final", 32'(out_data), 32'(mk(0, 0, 1, 120)));

    // Independent motors from zero.
    $display("[TB] independent motors");
    doReset();
    w0 = n_writes;
    applyStimulus(4'd2, mk(0, 300, 0, 100));
    settle("t3_settle", 100);
    checkOutput("t3_writes", 32'(n_writes - w0), 32'd3);
    checkOutput("t3_final", 32'(out_data), 32'(mk(0, 300, 0, 100)));

    // Command landing on a tick cycle mid-ramp.
    $display("[TB] collision");
    applyStimulus(4'd5, mk(0, 300, 0, 900));
    waitCycles(2 * TICK_DIV);
    n = 0;
    while (m_cnt != TICK_DIV - 1 && n < TICK_DIV + 2) begin @(negedge clk); n++; end
    if (n >= TICK_DIV + 2) timeoutFail("t4_align");
    applyStimulus(4'd6, mk(1, 0, 0, 0));
    checkOutput("t4_tag", 32'(out_ctrl), 32'd6);
    settle("t4_settle", 200);

    // Reset while ramping 200 -> 500.
    $display("[TB] reset mid-ramp");
    applyStimulus(4'd7, mk(0, 0, 0, 500));
    waitPwm1("t5_wait", 200, 100);
    doReset();
    checkOutput("t5_out_wr", 32'(out_wr), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    w0 = n_writes;
    waitCycles(5 * TICK_DIV);
    checkOutput("t5_no_writes", 32'(n_writes - w0), 32'd0);

`ifdef RAMP_ESTOP_EN
    $display("[TB] estop");
    applyStimulus(4'd8, mk(0, 0, 0, 600));
    waitPwm1("t6_wait", 300, 100);
    estop = 1'b1;
    applyStimulus(4'd9, mk(0, 700, 0, 700));
    checkOutput("t6_wr", 32'(out_wr), 32'd1);
    checkOutput("t6_ctrl", 32'(out_ctrl), 32'hE);
    checkOutput("t6_pwm", 32'(out_data & 24'h7FF7FF), 32'd0);
    applyStimulus(4'd9, mk(0, 700, 0, 700));
    waitCycles(2);
    estop = 1'b0;
    settle("t6_settle", 100);
`endif

    // Random commands with occasional resets.
    $display("[TB] random");
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 15) == 0) doReset();
      applyStimulus(4'($urandom), 24'($urandom));
      waitCycles($urandom_range(1, 60));
    end
    settle("rand_settle", 200);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
